// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : operation encoding on op_i
//   - mdu_state_e : controller states
//   - is_div / is_signed : operation decode helpers
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_state_e;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_cneg.sv
// mdu_cneg: conditional two's-complement negate.
// Ports:
//   i_val [W-1:0] : input value
//   i_neg         : 1 = negate, 0 = pass through
//   o_val [W-1:0] : result
module mdu_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO result registers.
// One result bit per cycle: shift-add multiply, restoring divide; signed ops
// run on magnitudes and are sign-corrected in FIXUP.
// Optional build macro: MDU_EARLY_OUT_EN (multiply leaves CALC as soon as the
// remaining multiplier bits are zero; results unchanged).
// Ports:
//   clk_i, rst_i (async, active low)
//   valid_i / ready_o     : request handshake
//   op_i, a_i, b_i        : operation and operands
//   flush_i               : abort in-flight op, block accept
//   busy_o, done_o, div0_o: status
//   hi_o, lo_o            : HI/LO registers
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one multiply/divide step per cycle, counter WIDTH-1 down to 0
// FIXUP | sign correction, HI/LO written at the end of this cycle
// DONE  | done_o pulse; may accept the next request
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e           r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div, r_neg_a, r_neg_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_div0;

  logic                 w_ready, w_accept, w_div0_in, w_calc_last;
  logic                 w_neg_a_in, w_neg_b_in;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_rem_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_diff, w_rem_nxt, w_quo_nxt;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  assign w_ready    = (r_state == IDLE) || (r_state == DONE);
  assign w_accept   = valid_i & w_ready & ~flush_i;
  assign w_div0_in  = is_div(op_i) && (b_i == '0);
  assign w_neg_a_in = is_signed(op_i) & a_i[WIDTH-1];
  assign w_neg_b_in = is_signed(op_i) & b_i[WIDTH-1];

  mdu_cneg #(.W(WIDTH)) u_mag_a (.i_val(a_i), .i_neg(w_neg_a_in), .o_val(w_mag_a));
  mdu_cneg #(.W(WIDTH)) u_mag_b (.i_val(b_i), .i_neg(w_neg_b_in), .o_val(w_mag_b));

  // Multiply step: add the left-shifting multiplicand when the current
  // multiplier bit is set.
  assign w_mul_acc = r_acc + (r_opb[0] ? r_mcand : '0);

  // Restoring divide step: r_acc holds {remainder, dividend/quotient}.
  // A set top bit of the shifted remainder already guarantees it exceeds the
  // divisor, so the W-bit difference is exact whenever w_ge is true.
  assign w_rem_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge        = w_rem_shift[WIDTH] | (w_rem_shift[WIDTH-1:0] >= r_opb);
  assign w_rem_diff  = w_rem_shift[WIDTH-1:0] - r_opb;
  assign w_rem_nxt   = w_ge ? w_rem_diff : w_rem_shift[WIDTH-1:0];
  assign w_quo_nxt   = {r_acc[WIDTH-2:0], w_ge};

  mdu_cneg #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_prod_fix));
  mdu_cneg #(.W(WIDTH)) u_fix_quo (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_quo_fix));
  mdu_cneg #(.W(WIDTH)) u_fix_rem (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_a), .o_val(w_rem_fix));

`ifdef MDU_EARLY_OUT_EN
  assign w_calc_last = (r_cnt == '0) || (!r_is_div && (r_opb[WIDTH-1:1] == '0));
`else
  assign w_calc_last = (r_cnt == '0);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          if (w_div0_in) w_state_nxt = DONE;
`ifdef MDU_EARLY_OUT_EN
          else if (!is_div(op_i) && (w_mag_b == '0)) w_state_nxt = FIXUP;
`endif
          else w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (flush_i)          w_state_nxt = IDLE;
        else if (w_calc_last) w_state_nxt = FIXUP;
      end
      FIXUP:   w_state_nxt = flush_i ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (r_state)
      IDLE:        ready_o = 1'b1;
      CALC, FIXUP: busy_o  = 1'b1;
      DONE: begin
        ready_o = 1'b1;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH - 1);
      r_is_div <= is_div(op_i);
      r_neg_a  <= w_neg_a_in;
      r_neg_b  <= w_neg_b_in;
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_opb    <= w_mag_b;
      r_acc    <= is_div(op_i) ? {{WIDTH{1'b0}}, w_mag_a} : '0;
      if (w_div0_in) begin
        r_hi   <= a_i;
        r_lo   <= '1;
        r_div0 <= 1'b1;
      end
    end else if ((r_state == CALC) && !flush_i) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_is_div) begin
        r_acc <= {w_rem_nxt, w_quo_nxt};
      end else begin
        r_acc   <= w_mul_acc;
        r_mcand <= r_mcand << 1;
        r_opb   <= r_opb >> 1;
      end
    end else if ((r_state == FIXUP) && !flush_i) begin
      r_div0 <= 1'b0;
      if (r_is_div) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
        r_lo <= w_prod_fix[WIDTH-1:0];
      end
    end
  end

  assign div0_o = r_div0;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32).
// Expected results come from a behavioural model and are queued at issue,
// then popped and compared when done_o is seen.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         d0;
    logic [7:0]   lat;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         flush_i = 1'b0;
  logic         busy_o, done_o, div0_o;
  logic [W-1:0] hi_o, lo_o;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  mdu_iter #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .div0_o(div0_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    if ((op == MDU_DIV || op == MDU_DIVU) && b == '0) return 8'd1;
`ifdef MDU_EARLY_OUT_EN
    if (op == MDU_MULT || op == MDU_MULTU) begin
      logic [W-1:0] mag;
      int msb;
      mag = (op == MDU_MULT && b[W-1]) ? -b : b;
      if (mag == '0) return 8'd2;
      msb = 0;
      for (int i = 0; i < W; i++) if (mag[i]) msb = i;
      return 8'(msb + 3);
    end
`endif
    return 8'(W + 2);
  endfunction

  function automatic exp_t make_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic sgn;
    logic signed [2*W-1:0] sa, sb, sq, sr;
    logic [2*W-1:0] p;
    sgn = (op == MDU_MULT) || (op == MDU_DIV);
    sa = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    e.d0 = 1'b0;
    e.lat = exp_lat(op, b);
    if (op == MDU_MULT || op == MDU_MULTU) begin
      p = sa * sb;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.d0 = 1'b1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      e.hi = sr[W-1:0];
      e.lo = sq[W-1:0];
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit wait_neg);
    if (wait_neg) @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    sb_q.push_back(make_exp(op, a, b));
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_done(output logic [7:0] lat, output logic [W-1:0] hi, output logic [W-1:0] lo, output logic d0);
    lat = 8'd0; hi = 'x; lo = 'x; d0 = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = 8'(i); hi = hi_o; lo = lo_o; d0 = div0_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    n_vec++;
    if ({ready_o, busy_o, done_o, div0_o, hi_o, lo_o} !== {4'b1000, {W{1'b0}}, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL reset: got rdy=%b busy=%b done=%b d0=%b hi=%h lo=%h, want 1 0 0 0 0 0",
               ready_o, busy_o, done_o, div0_o, hi_o, lo_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_mult();
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
      n_err++;
      $display("FAIL mult_model: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
               lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
    end
    n_vec++;
    if ({hi, lo, d0} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin
      n_err++;
      $display("FAIL mult_m3x7: got hi=%h lo=%h d0=%b, want hi=ffffffff lo=ffffffeb d0=0", hi, lo, d0);
    end
  endtask

  task automatic test_div();
    logic [1:0]   ops [4] = '{MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIVU};
    logic [W-1:0] as  [4] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd16};
    logic [W-1:0] hs  [4] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd15};
    logic [W-1:0] ls  [4] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0FFF_FFFF};
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      wait_done(lat, hi, lo, d0);
      e = sb_q.pop_front();
      n_vec++;
      if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
        n_err++;
        $display("FAIL div_model[%0d]: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
                 i, lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
      end
      n_vec++;
      if ({hi, lo, d0} !== {hs[i], ls[i], 1'b0}) begin
        n_err++;
        $display("FAIL div_const[%0d]: got hi=%h lo=%h d0=%b, want hi=%h lo=%h d0=0", i, hi, lo, d0, hs[i], ls[i]);
      end
    end
  endtask

  task automatic test_div0();
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    issue(MDU_DIV, 32'h1234_5678, 32'd0, 1'b1);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {8'd1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1} ||
        {lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
      n_err++;
      $display("FAIL div0: got lat=%0d hi=%h lo=%h d0=%b, want lat=1 hi=12345678 lo=ffffffff d0=1", lat, hi, lo, d0);
    end
    // sticky until the next completion without divide by zero
    @(negedge clk_i);
    n_vec++;
    if (div0_o !== 1'b1) begin
      n_err++;
      $display("FAIL div0_sticky: got div0=%b, want 1", div0_o);
    end
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
      n_err++;
      $display("FAIL div0_clear: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
               lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
    end
  endtask

  task automatic test_random();
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    logic [1:0] op; logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(1, 255)) : $urandom;
      if (i == 5) b = 32'hFFFF_FFFF;
      issue(op, a, b, 1'b1);
      wait_done(lat, hi, lo, d0);
      e = sb_q.pop_front();
      n_vec++;
      if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
                 i, op, a, b, lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e, prev;
    bit saw_done;
    issue(MDU_MULTU, 32'd9, 32'd9, 1'b1);
    wait_done(lat, hi, lo, d0);
    prev = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {prev.lat, prev.hi, prev.lo, prev.d0}) begin
      n_err++;
      $display("FAIL flush_pre: got lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h", lat, hi, lo, prev.lat, prev.hi, prev.lo);
    end
    issue(MDU_MULTU, 32'd5, 32'd6, 1'b1);
    e = sb_q.pop_back();
    for (int i = 0; i < 10; i++) @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({ready_o, busy_o, done_o, hi_o, lo_o, div0_o} !== {3'b100, prev.hi, prev.lo, prev.d0}) begin
      n_err++;
      $display("FAIL flush_calc: got rdy=%b busy=%b done=%b hi=%h lo=%h d0=%b, want 1 0 0 hi=%h lo=%h d0=%b",
               ready_o, busy_o, done_o, hi_o, lo_o, div0_o, prev.hi, prev.lo, prev.d0);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_done: got done seen=%b, want 0", saw_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    issue(MDU_MULTU, 32'd5, 32'd6, 1'b1);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
               lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
    end
    issue(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {8'd34, 32'd1, 32'd0, 1'b0} || {lat, hi, lo} !== {e.lat, e.hi, e.lo}) begin
      n_err++;
      $display("FAIL b2b_second: got gap=%0d hi=%h lo=%h d0=%b, want gap=34 hi=1 lo=0 d0=0", lat, hi, lo, d0);
    end
    @(negedge clk_i);
    n_vec++;
    if ({done_o, ready_o} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_pulse: got done=%b rdy=%b after pulse, want done=0 rdy=1", done_o, ready_o);
    end
  endtask

  task automatic test_flush_done();
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    issue(MDU_DIVU, 32'd1000, 32'd3, 1'b1);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
      n_err++;
      $display("FAIL fdone_op: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
               lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
    end
    op_i = MDU_MULTU; a_i = 32'd2; b_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i);
    #1 begin valid_i = 1'b0; flush_i = 1'b0; end
    @(negedge clk_i);
    n_vec++;
    if ({ready_o, busy_o, done_o, hi_o, lo_o} !== {3'b100, e.hi, e.lo}) begin
      n_err++;
      $display("FAIL fdone_block: got rdy=%b busy=%b done=%b hi=%h lo=%h, want 1 0 0 hi=%h lo=%h",
               ready_o, busy_o, done_o, hi_o, lo_o, e.hi, e.lo);
    end
  endtask

  task automatic test_early_out();
    logic [1:0]   ops [3] = '{MDU_MULT, MDU_MULTU, MDU_MULT};
    logic [W-1:0] as  [3] = '{32'd0, 32'd5, 32'd11};
    logic [W-1:0] bs  [3] = '{32'hDEAD_BEEF, 32'd3, 32'hFFFF_FFFF};
    logic [7:0] lat; logic [W-1:0] hi, lo; logic d0; exp_t e;
    issue(MDU_MULT, 32'd0, 32'd0, 1'b1);
    wait_done(lat, hi, lo, d0);
    e = sb_q.pop_front();
    n_vec++;
    if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
      n_err++;
      $display("FAIL early_zero: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
               lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
    end
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      wait_done(lat, hi, lo, d0);
      e = sb_q.pop_front();
      n_vec++;
      if ({lat, hi, lo, d0} !== {e.lat, e.hi, e.lo, e.d0}) begin
        n_err++;
        $display("FAIL early[%0d]: got lat=%0d hi=%h lo=%h d0=%b, want lat=%0d hi=%h lo=%h d0=%b",
                 i, lat, hi, lo, d0, e.lat, e.hi, e.lo, e.d0);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    issue(MDU_MULT, 32'd123, 32'hFFFF_FFFB, 1'b1);
    e = sb_q.pop_back();
    for (int i = 0; i < 5; i++) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    n_vec++;
    if ({ready_o, busy_o, done_o, div0_o, hi_o, lo_o} !== {4'b1000, {W{1'b0}}, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%b busy=%b done=%b d0=%b hi=%h lo=%h, want 1 0 0 0 0 0",
               ready_o, busy_o, done_o, div0_o, hi_o, lo_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if ({ready_o, busy_o, done_o} !== 3'b100) begin
      n_err++;
      $display("FAIL post_reset: got rdy=%b busy=%b done=%b, want 1 0 0", ready_o, busy_o, done_o);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_random();
    test_flush();
    test_back_to_back();
    test_flush_done();
    test_early_out();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
